// File: rtl/icache_direct_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
// - state_t        : FSM state encoding (2-bit)
// - INDEX_BITS_DEF : default index width (16 lines)
// - ADDR_BITS_DEF  : default address width
package icache_direct_pkg;

  localparam int INDEX_BITS_DEF = 4;
  localparam int ADDR_BITS_DEF  = 32;

  typedef enum logic [1:0] {
    ICACHE_IDLE = 2'd0,
    ICACHE_MISS = 2'd1,
    ICACHE_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/icache_direct_if.sv
// Fetcher + memory-controller handshake bundle for icache_direct.
// Fetch side : fetch_valid/fetch_pc in, inst_ready/inst out.
// Memory side: mem_need/mem_addr out, mem_ready/mem_ins in.
// slave  = the cache's view, master = the environment (fetcher + memctrl).
interface icache_direct_if #(
  parameter int ADDR_BITS = 32
);
  logic                 fetch_valid;
  logic [ADDR_BITS-1:0] fetch_pc;
  logic                 inst_ready;
  logic [31:0]          inst;
  logic                 mem_need;
  logic [ADDR_BITS-1:0] mem_addr;
  logic                 mem_ready;
  logic [31:0]          mem_ins;

  modport slave (
    input  fetch_valid, fetch_pc, mem_ready, mem_ins,
    output inst_ready, inst, mem_need, mem_addr
  );

  modport master (
    output fetch_valid, fetch_pc, mem_ready, mem_ins,
    input  inst_ready, inst, mem_need, mem_addr
  );
endinterface

// File: rtl/icache_direct_line_ram.sv
// Line storage for the direct-mapped cache: valid bits, tags, data words.
// Ports: clk, clr_n (sync active-low valid clear), we/wr_idx/wr_tag/wr_data
// (synchronous fill), rd_idx -> rd_valid/rd_tag/rd_data (combinational read).
module icache_direct_line_ram #(
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 26
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [31:0]           wr_data,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [31:0]           rd_data
);
  localparam int LINES = 2 ** INDEX_BITS;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [LINES];

  // Only valid bits need clearing; stale tag/data behind a clear bit is harmless.
  always_ff @(posedge clk) begin
    if (!clr_n) valid <= '0;
    else if (we) valid[wr_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];
endmodule

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache.
// Ports: clk_in, rst_in (sync active-low), rdy_in (0 = freeze),
// clear_in (pipeline flush), bus (icache_direct_if.slave: fetch + memctrl).
// Hits answer one cycle after the request is sampled; misses fetch a word
// from memctrl, fill the line, then deliver unless a flush intervened.
module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEF,
  parameter int ADDR_BITS  = ADDR_BITS_DEF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear_in,
  icache_direct_if.slave    bus
);
  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - 2;

  state_t                  state;
  logic                    drop;
  logic [ADDR_BITS-1:2]    miss_pc;

  logic [INDEX_BITS-1:0]   rd_idx;
  logic [TAG_BITS-1:0]     pc_tag;
  logic                    rd_valid;
  logic [TAG_BITS-1:0]     rd_tag;
  logic [31:0]             rd_data;
  logic                    hit;
  logic                    fill;
  logic                    pc_lsb_unused;

  assign rd_idx        = bus.fetch_pc[INDEX_BITS+1:2];
  assign pc_tag        = bus.fetch_pc[ADDR_BITS-1:INDEX_BITS+2];
  assign hit           = rd_valid && (rd_tag == pc_tag);
  assign pc_lsb_unused = ^bus.fetch_pc[1:0];

  // Fill happens on the mem_ready edge in MISS regardless of clear/drop:
  // the memctrl transaction completed, so the line is still worth keeping.
  assign fill = rdy_in && (state == ICACHE_MISS) && bus.mem_ready;

  icache_direct_line_ram #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_ram (
    .clk      (clk_in),
    .clr_n    (rst_in),
    .we       (fill),
    .wr_idx   (miss_pc[INDEX_BITS+1:2]),
    .wr_tag   (miss_pc[ADDR_BITS-1:INDEX_BITS+2]),
    .wr_data  (bus.mem_ins),
    .rd_idx   (rd_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state          <= ICACHE_IDLE;
      drop           <= 1'b0;
      miss_pc        <= '0;
      bus.inst_ready <= 1'b0;
      bus.inst       <= '0;
      bus.mem_need   <= 1'b0;
      bus.mem_addr   <= '0;
    end else if (rdy_in) begin
      case (state)
        ICACHE_IDLE: begin
          bus.inst_ready <= 1'b0;
          if (!clear_in && bus.fetch_valid) begin
            if (hit) begin
              bus.inst       <= rd_data;
              bus.inst_ready <= 1'b1;
            end else begin
              bus.mem_need <= 1'b1;
              bus.mem_addr <= {bus.fetch_pc[ADDR_BITS-1:2], 2'b00};
              miss_pc      <= bus.fetch_pc[ADDR_BITS-1:2];
              state        <= ICACHE_MISS;
            end
          end
        end
        ICACHE_MISS: begin
          if (bus.mem_ready) begin
            bus.mem_need <= 1'b0;
            bus.mem_addr <= '0;
            if (!drop && !clear_in) begin
              bus.inst       <= bus.mem_ins;
              bus.inst_ready <= 1'b1;
            end
            drop  <= 1'b0;
            state <= ICACHE_RESP;
          end else if (clear_in) begin
            // Cannot abort memctrl; remember to discard the word instead.
            drop <= 1'b1;
          end
        end
        ICACHE_RESP: begin
          // Idle one cycle while memctrl stalls after ins_ready.
          bus.inst_ready <= 1'b0;
          state          <= ICACHE_IDLE;
        end
        default: state <= ICACHE_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_direct.sv
module tb_icache_direct;
  logic clk = 1'b0;
  logic rst_in, rdy_in, clear_in;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  icache_direct_if #(.ADDR_BITS(32)) bus ();

  icache_direct #(.INDEX_BITS(4), .ADDR_BITS(32)) dut (
    .clk_in   (clk),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .clear_in (clear_in),
    .bus      (bus)
  );

  // Backing memory for addresses 0x00..0xFC, and a reference cache model:
  // each of the 16 lines remembers which word address it holds.
  logic [31:0] mem_img [64];
  bit          m_valid [16];
  logic [29:0] m_word  [16];

  typedef struct {
    logic [31:0] pc;
    int          lat;
    bit          miss;
    logic [31:0] data;
  } vec_t;
  vec_t vec [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present a request and act as memctrl for it; returns what came back.
  task automatic do_fetch(input logic [31:0] pc, input int lat, output bit missed,
                          output bit got, output logic [31:0] ins, output int cyc);
    missed = 0; got = 0; ins = '0; cyc = 0;
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = pc;
    while (!got && cyc < 50) begin
      tick(); cyc++;
      if (bus.mem_need && !missed) begin
        missed = 1;
        chk("miss_addr", bus.mem_addr, {pc[31:2], 2'b00});
        for (int i = 0; i < lat; i++) begin
          tick(); cyc++;
          chk("need_held", {31'd0, bus.mem_need}, 32'd1);
        end
        bus.mem_ready = 1'b1;
        bus.mem_ins   = mem_img[pc[7:2]];
        tick(); cyc++;
        bus.mem_ready = 1'b0;
        chk("need_drop", {31'd0, bus.mem_need}, 32'd0);
      end
      if (bus.inst_ready) begin
        got = 1;
        ins = bus.inst;
      end
    end
    bus.fetch_valid = 1'b0;
  endtask

  task automatic run_one(input logic [31:0] pc, input int lat, input bit exp_miss,
                         input logic [31:0] exp_ins);
    bit missed, got;
    logic [31:0] ins;
    int cyc;
    do_fetch(pc, lat, missed, got, ins, cyc);
    chk("ready_seen", {31'd0, got}, 32'd1);
    chk("miss_flag", {31'd0, missed}, {31'd0, exp_miss});
    chk("inst", ins, exp_ins);
    if (!exp_miss) chk("hit_latency", cyc, 32'd1);
    tick();
    chk("pulse_end", {31'd0, bus.inst_ready}, 32'd0);
    chk("need_idle", {31'd0, bus.mem_need}, 32'd0);
    m_valid[pc[5:2]] = 1;
    m_word[pc[5:2]]  = pc[31:2];
  endtask

  task automatic model_fetch(input logic [31:0] pc, input int lat);
    bit m;
    m = !(m_valid[pc[5:2]] && m_word[pc[5:2]] == pc[31:2]);
    run_one(pc, lat, m, mem_img[pc[7:2]]);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem_img[i] = $urandom;
    mem_img[0]  = 32'h0000_0513;
    mem_img[2]  = 32'hDEAD_BEEF;
    mem_img[16] = 32'h1111_1111;
    mem_img[17] = 32'hA5A5_0044;
    model_clear();

    vec[0] = '{32'h00, 2, 1'b1, 32'h0000_0513};
    vec[1] = '{32'h00, 0, 1'b0, 32'h0000_0513};
    vec[2] = '{32'h40, 1, 1'b1, 32'h1111_1111};
    vec[3] = '{32'h00, 3, 1'b1, 32'h0000_0513};
    vec[4] = '{32'h40, 0, 1'b1, 32'h1111_1111};
    vec[5] = '{32'h44, 2, 1'b1, 32'hA5A5_0044};
    vec[6] = '{32'h44, 0, 1'b0, 32'hA5A5_0044};

    rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0;
    bus.fetch_valid = 1'b0; bus.fetch_pc = '0;
    bus.mem_ready = 1'b0; bus.mem_ins = '0;
    repeat (3) tick();
    chk("rst_ready", {31'd0, bus.inst_ready}, 32'd0);
    chk("rst_inst", bus.inst, 32'd0);
    chk("rst_need", {31'd0, bus.mem_need}, 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    rst_in = 1'b1;
    tick();

    // Cold miss, hit after fill, conflict eviction.
    for (int i = 0; i < 7; i++) run_one(vec[i].pc, vec[i].lat, vec[i].miss, vec[i].data);

    // Flush while in MISS: word still fills the line, nothing delivered.
    bus.fetch_valid = 1'b1; bus.fetch_pc = 32'h08;
    tick();
    chk("clr_need", {31'd0, bus.mem_need}, 32'd1);
    clear_in = 1'b1; bus.fetch_valid = 1'b0;
    tick();
    clear_in = 1'b0;
    tick(); tick();
    bus.mem_ready = 1'b1; bus.mem_ins = mem_img[2];
    tick();
    bus.mem_ready = 1'b0;
    chk("clr_no_ready", {31'd0, bus.inst_ready}, 32'd0);
    chk("clr_need_off", {31'd0, bus.mem_need}, 32'd0);
    tick();
    chk("clr_no_ready2", {31'd0, bus.inst_ready}, 32'd0);
    m_valid[2] = 1; m_word[2] = 30'h2;

    // Flush coincident with a hit in IDLE, then a stray mem_ready in IDLE.
    bus.fetch_valid = 1'b1; bus.fetch_pc = 32'h08; clear_in = 1'b1;
    tick();
    clear_in = 1'b0; bus.fetch_valid = 1'b0;
    chk("hitclr_no_ready", {31'd0, bus.inst_ready}, 32'd0);
    bus.mem_ready = 1'b1; bus.mem_ins = 32'hBAD0_BAD0;
    tick();
    bus.mem_ready = 1'b0;
    chk("stray_no_ready", {31'd0, bus.inst_ready}, 32'd0);
    chk("stray_no_need", {31'd0, bus.mem_need}, 32'd0);
    run_one(32'h08, 0, 1'b0, 32'hDEAD_BEEF);

    // Flush on the same edge as mem_ready.
    bus.fetch_valid = 1'b1; bus.fetch_pc = 32'h0C;
    tick();
    chk("cm_need", {31'd0, bus.mem_need}, 32'd1);
    bus.mem_ready = 1'b1; bus.mem_ins = mem_img[3]; clear_in = 1'b1; bus.fetch_valid = 1'b0;
    tick();
    bus.mem_ready = 1'b0; clear_in = 1'b0;
    chk("cm_no_ready", {31'd0, bus.inst_ready}, 32'd0);
    chk("cm_need_off", {31'd0, bus.mem_need}, 32'd0);
    tick();
    m_valid[3] = 1; m_word[3] = 30'h3;
    run_one(32'h0C, 0, 1'b0, mem_img[3]);

    // Freeze mid-MISS; a flush while frozen must be ignored.
    bus.fetch_valid = 1'b1; bus.fetch_pc = 32'h10;
    tick();
    chk("frz_need", {31'd0, bus.mem_need}, 32'd1);
    rdy_in = 1'b0; clear_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      clear_in = 1'b0;
      chk("frz_need_hold", {31'd0, bus.mem_need}, 32'd1);
      chk("frz_addr_hold", bus.mem_addr, 32'h10);
      chk("frz_no_ready", {31'd0, bus.inst_ready}, 32'd0);
    end
    rdy_in = 1'b1;
    tick();
    chk("frz_still_need", {31'd0, bus.mem_need}, 32'd1);
    bus.mem_ready = 1'b1; bus.mem_ins = mem_img[4];
    tick();
    bus.mem_ready = 1'b0; bus.fetch_valid = 1'b0;
    chk("frz_ready", {31'd0, bus.inst_ready}, 32'd1);
    chk("frz_inst", bus.inst, mem_img[4]);
    tick();
    chk("frz_pulse_end", {31'd0, bus.inst_ready}, 32'd0);
    m_valid[4] = 1; m_word[4] = 30'h4;

    // Reset while in MISS drops everything including valid bits.
    bus.fetch_valid = 1'b1; bus.fetch_pc = 32'h30;
    tick();
    chk("rm_need", {31'd0, bus.mem_need}, 32'd1);
    rst_in = 1'b0;
    tick();
    chk("rm_need_off", {31'd0, bus.mem_need}, 32'd0);
    chk("rm_addr", bus.mem_addr, 32'd0);
    chk("rm_ready", {31'd0, bus.inst_ready}, 32'd0);
    chk("rm_inst", bus.inst, 32'd0);
    rst_in = 1'b1; bus.fetch_valid = 1'b0;
    model_clear();
    tick();
    run_one(32'h08, 1, 1'b1, 32'hDEAD_BEEF);

    // Random traffic against the line model.
    for (int i = 0; i < 150; i++)
      model_fetch({24'd0, 6'($urandom_range(0, 63)), 2'b00}, $urandom_range(0, 3));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
